// File: rtl/pcie_rx_tlp_decoder.sv
// Decodes MWr/MRd (3DW/4DW) and successful CplD TLPs from the 64-bit PCIe RX stream; latency 2 clocks beat-to-output.
// No backpressure: every beat is accepted; tvalid low stalls decoding. Optional stat counters under PCIE_RX_STATS_EN.
// Dropped TLPs (unsupported, poisoned, malformed) are consumed until tlast without producing output.
module pcie_rx_tlp_decoder #(
    parameter int ADDR_WIDTH      = 13,
    parameter int CPL_INDEX_WIDTH = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tvalid,
    input  logic                       tlast,
    input  logic [63:0]                tdata,
    output logic                       write_valid,
    output logic [ADDR_WIDTH-1:0]      write_address,
    output logic [63:0]                write_data,
    output logic                       read_valid,
    output logic [ADDR_WIDTH-1:0]      read_address,
    output logic [1:0]                 read_dw_count,
    output logic [23:0]                rid_tag,
    output logic                       completion_valid,
    output logic [7:0]                 completion_tag,
    output logic [CPL_INDEX_WIDTH-1:0] completion_index,
    output logic [63:0]                completion_data,
    output logic [15:0]                stat_writes,
    output logic [15:0]                stat_reads,
    output logic [15:0]                stat_cpls,
    output logic [15:0]                stat_drops
);

    localparam logic [1:0] HDR01 = 2'd0;
    localparam logic [1:0] HDR23 = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] DROP  = 2'd3;

    logic [1:0]                 state;
    logic                       in_vld;
    logic                       in_last;
    logic [63:0]                in_data;
    logic [31:0]                prev_hi;
    logic                       is_wr;
    logic                       is_rd;
    logic                       is_cpl;
    logic                       is_4dw;
    logic                       hdr_bad;
    logic [9:0]                 rem_words;
    logic [ADDR_WIDTH-1:0]      addr_ptr;
    logic [CPL_INDEX_WIDTH-1:0] idx_ptr;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic [6:0]  fmt_type;
    logic [9:0]  hdr_len;
    logic [9:0]  hdr_words;
    logic        dec_wr;
    logic        dec_rd;
    logic        dec_cpl;
    logic        dec_4dw;
    logic        dec_known;
    logic        dec_bad;

    assign fmt_type  = in_data[30:24];
    assign hdr_len   = in_data[9:0];
    // A length field of zero encodes 1024 DWs, i.e. 512 words
    assign hdr_words = (hdr_len == 10'd0) ? 10'd512 : {1'b0, hdr_len[9:1]};

    always_comb begin
        dec_wr    = 1'b0;
        dec_rd    = 1'b0;
        dec_cpl   = 1'b0;
        dec_4dw   = 1'b0;
        dec_known = 1'b1;
        case (fmt_type)
            7'h40: dec_wr = 1'b1;
            7'h60: begin dec_wr = 1'b1; dec_4dw = 1'b1; end
            7'h00: dec_rd = 1'b1;
            7'h20: begin dec_rd = 1'b1; dec_4dw = 1'b1; end
            7'h4A: dec_cpl = 1'b1;
            default: dec_known = 1'b0;
        endcase
        dec_bad = !dec_known || in_data[14]
                || (dec_wr && hdr_len[0])
                || (dec_rd && (hdr_len != 10'd1) && (hdr_len != 10'd2))
                || (dec_cpl && (in_data[47:45] != 3'd0));
    end

    // The 4DW header carries the low address DW in DW3; the upper DW2 is ignored
    logic [ADDR_WIDTH-1:0] addr_bits;
    logic                  addr_bit2;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  cpl_ok;
    logic [63:0]           data_word;

    assign addr_bits = is_4dw ? in_data[ADDR_WIDTH+34:35] : in_data[ADDR_WIDTH+2:3];
    assign addr_bit2 = is_4dw ? in_data[34] : in_data[2];
    assign wr_ok     = is_wr && !hdr_bad && !addr_bit2;
    assign rd_ok     = is_rd && !hdr_bad;
    assign cpl_ok    = is_cpl && !hdr_bad;
    assign data_word = is_4dw ? {bswap(in_data[63:32]), bswap(in_data[31:0])}
                              : {bswap(in_data[31:0]), bswap(prev_hi)};

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= HDR01;
            in_vld           <= 1'b0;
            in_last          <= 1'b0;
            in_data          <= '0;
            prev_hi          <= '0;
            is_wr            <= 1'b0;
            is_rd            <= 1'b0;
            is_cpl           <= 1'b0;
            is_4dw           <= 1'b0;
            hdr_bad          <= 1'b0;
            rem_words        <= '0;
            addr_ptr         <= '0;
            idx_ptr          <= '0;
            write_valid      <= 1'b0;
            write_address    <= '0;
            write_data       <= '0;
            read_valid       <= 1'b0;
            read_address     <= '0;
            read_dw_count    <= '0;
            rid_tag          <= '0;
            completion_valid <= 1'b0;
            completion_tag   <= '0;
            completion_index <= '0;
            completion_data  <= '0;
        end else begin
            in_vld           <= tvalid;
            in_last          <= tlast;
            in_data          <= tdata;
            write_valid      <= 1'b0;
            read_valid       <= 1'b0;
            completion_valid <= 1'b0;
            if (in_vld) begin
                prev_hi <= in_data[63:32];
                case (state)
                    HDR01: begin
                        is_wr         <= dec_wr;
                        is_rd         <= dec_rd;
                        is_cpl        <= dec_cpl;
                        is_4dw        <= dec_4dw;
                        hdr_bad       <= dec_bad;
                        rem_words     <= hdr_words;
                        rid_tag       <= in_data[63:40];
                        read_dw_count <= hdr_len[1:0];
                        idx_ptr       <= '0 - in_data[CPL_INDEX_WIDTH+34:35];
                        state         <= in_last ? HDR01 : HDR23;
                    end
                    HDR23: begin
                        addr_ptr       <= addr_bits;
                        read_address   <= addr_bits;
                        completion_tag <= in_data[15:8];
                        read_valid     <= rd_ok;
                        if (in_last)
                            state <= HDR01;
                        else if (wr_ok || cpl_ok)
                            state <= DATA;
                        else
                            state <= DROP;
                    end
                    DATA: begin
                        // Words beyond the header length are ignored until tlast
                        if (rem_words != 10'd0) begin
                            rem_words <= rem_words - 10'd1;
                            if (is_wr) begin
                                write_valid   <= 1'b1;
                                write_address <= addr_ptr;
                                write_data    <= data_word;
                                addr_ptr      <= addr_ptr + 1'b1;
                            end else begin
                                completion_valid <= 1'b1;
                                completion_index <= idx_ptr;
                                completion_data  <= data_word;
                                idx_ptr          <= idx_ptr + 1'b1;
                            end
                        end
                        if (in_last)
                            state <= HDR01;
                    end
                    default: begin
                        if (in_last)
                            state <= HDR01;
                    end
                endcase
            end
        end
    end

`ifdef PCIE_RX_STATS_EN
    logic decide;
    assign decide = in_vld && (state == HDR23);

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_writes <= '0;
            stat_reads  <= '0;
            stat_cpls   <= '0;
            stat_drops  <= '0;
        end else if (decide) begin
            if (wr_ok && (stat_writes != 16'hFFFF))
                stat_writes <= stat_writes + 16'd1;
            if (rd_ok && (stat_reads != 16'hFFFF))
                stat_reads <= stat_reads + 16'd1;
            if (cpl_ok && (stat_cpls != 16'hFFFF))
                stat_cpls <= stat_cpls + 16'd1;
            if (!(wr_ok || rd_ok || cpl_ok) && (stat_drops != 16'hFFFF))
                stat_drops <= stat_drops + 16'd1;
        end
    end
`else
    assign stat_writes = '0;
    assign stat_reads  = '0;
    assign stat_cpls   = '0;
    assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_pcie_rx_tlp_decoder.sv
// Randomized scoreboard bench for pcie_rx_tlp_decoder: a DW-level TLP model queues expected outputs,
// a negedge monitor pops and compares whenever a valid is presented.
module tb_pcie_rx_tlp_decoder;
    localparam int AW = 13;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic [63:0]   tdata = '0;
    logic          write_valid;
    logic [AW-1:0] write_address;
    logic [63:0]   write_data;
    logic          read_valid;
    logic [AW-1:0] read_address;
    logic [1:0]    read_dw_count;
    logic [23:0]   rid_tag;
    logic          completion_valid;
    logic [7:0]    completion_tag;
    logic [CW-1:0] completion_index;
    logic [63:0]   completion_data;
    logic [15:0]   stat_writes, stat_reads, stat_cpls, stat_drops;

    pcie_rx_tlp_decoder #(.ADDR_WIDTH(AW), .CPL_INDEX_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .tvalid(tvalid), .tlast(tlast), .tdata(tdata),
        .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
        .read_valid(read_valid), .read_address(read_address), .read_dw_count(read_dw_count),
        .rid_tag(rid_tag), .completion_valid(completion_valid), .completion_tag(completion_tag),
        .completion_index(completion_index), .completion_data(completion_data),
        .stat_writes(stat_writes), .stat_reads(stat_reads), .stat_cpls(stat_cpls),
        .stat_drops(stat_drops)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [AW-1:0] a; logic [63:0] d; } wr_t;
    typedef struct packed { logic [AW-1:0] a; logic [1:0] n; logic [23:0] rt; } rd_t;
    typedef struct packed { logic [7:0] tag; logic [CW-1:0] ix; logic [63:0] d; } cpl_t;

    wr_t  wq[$];
    rd_t  rq[$];
    cpl_t cq[$];
    wr_t  mw;
    rd_t  mr;
    cpl_t mc;

    int errors = 0;
    int checks = 0;
    int exp_wr = 0, exp_rd = 0, exp_cpl = 0, exp_drop = 0;
    logic [31:0] tlp[$];
    bit gap_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    always @(negedge clock) begin
        if (write_valid) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write actual=%0h expected=none", write_address);
            end else begin
                mw = wq.pop_front();
                check("write_address", write_address, mw.a);
                check("write_data", write_data, mw.d);
            end
        end
        if (read_valid) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read actual=%0h expected=none", read_address);
            end else begin
                mr = rq.pop_front();
                check("read_address", read_address, mr.a);
                check("read_dw_count", read_dw_count, mr.n);
                check("rid_tag", rid_tag, mr.rt);
            end
        end
        if (completion_valid) begin
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_cpl actual=%0h expected=none", completion_index);
            end else begin
                mc = cq.pop_front();
                check("completion_tag", completion_tag, mc.tag);
                check("completion_index", completion_index, mc.ix);
                check("completion_data", completion_data, mc.d);
            end
        end
    end

    task automatic mk_hdr0(input logic [6:0] ft, input int len, input bit ep);
        tlp.delete();
        tlp.push_back({1'b0, ft, 9'd0, ep, 4'd0, len[9:0]});
    endtask

    task automatic mk_mwr(input bit is4, input logic [63:0] addr, input int len, input bit ep);
        mk_hdr0(is4 ? 7'h60 : 7'h40, len, ep);
        tlp.push_back($urandom);
        if (is4) tlp.push_back(addr[63:32]);
        tlp.push_back(addr[31:0]);
        repeat (len) tlp.push_back($urandom);
    endtask

    task automatic mk_mrd(input bit is4, input logic [63:0] addr, input int len, input bit ep,
                          input logic [23:0] rt);
        mk_hdr0(is4 ? 7'h20 : 7'h00, len, ep);
        tlp.push_back({rt, 8'hFF});
        if (is4) tlp.push_back(addr[63:32]);
        tlp.push_back(addr[31:0]);
    endtask

    task automatic mk_cpl(input logic [11:0] bc, input logic [7:0] tag, input int len,
                          input logic [2:0] status, input bit ep);
        mk_hdr0(7'h4A, len, ep);
        tlp.push_back({16'hBEEF, status, 1'b0, bc});
        tlp.push_back({16'h1234, tag, 8'h00});
        repeat (len) tlp.push_back($urandom);
    endtask

    function automatic int full_beats();
        return (tlp.size() + 1) / 2;
    endfunction

    // Expected behaviour of the TLP currently in tlp[], delivered as nb beats
    task automatic model_tlp(input int nb);
        logic [31:0] d0, d1, a;
        logic [6:0]  ft;
        logic [CW-1:0] ix0;
        int hl, L, words;
        bit ep, ok;
        wr_t w; rd_t r; cpl_t c;
        if (nb < 2) return;
        d0 = tlp[0]; d1 = tlp[1];
        ft = d0[30:24]; ep = d0[14];
        L  = (d0[9:0] == 10'd0) ? 1024 : int'(d0[9:0]);
        hl = (ft == 7'h60 || ft == 7'h20) ? 4 : 3;
        a  = (hl == 4) ? tlp[3] : tlp[2];
        words = (2 * nb - hl) / 2;
        if (words > L / 2) words = L / 2;
        if (ft == 7'h40 || ft == 7'h60) begin
            ok = !ep && (L % 2 == 0) && !a[2];
            if (ok) begin
                exp_wr++;
                for (int k = 0; k < words; k++) begin
                    w.a = a[AW+2:3] + AW'(k);
                    w.d = {rev32(tlp[hl+2*k+1]), rev32(tlp[hl+2*k])};
                    wq.push_back(w);
                end
            end else exp_drop++;
        end else if (ft == 7'h00 || ft == 7'h20) begin
            ok = !ep && (L == 1 || L == 2);
            if (ok) begin
                exp_rd++;
                r.a = a[AW+2:3]; r.n = L[1:0]; r.rt = d1[31:8];
                rq.push_back(r);
            end else exp_drop++;
        end else if (ft == 7'h4A) begin
            ok = !ep && (d1[15:13] == 3'd0);
            if (ok) begin
                exp_cpl++;
                ix0 = CW'(0) - d1[CW+2:3];
                for (int k = 0; k < words; k++) begin
                    c.tag = tlp[2][15:8];
                    c.ix  = ix0 + CW'(k);
                    c.d   = {rev32(tlp[3+2*k+1]), rev32(tlp[3+2*k])};
                    cq.push_back(c);
                end
            end else exp_drop++;
        end else exp_drop++;
    endtask

    task automatic send(input int nb);
        for (int b = 0; b < nb; b++) begin
            if (gap_en)
                while ($urandom_range(0, 3) == 0) begin
                    tvalid = 1'b0; @(posedge clock); #1;
                end
            tvalid = 1'b1;
            tlast  = (b == nb - 1);
            tdata[31:0]  = tlp[2*b];
            tdata[63:32] = (2*b + 1 < tlp.size()) ? tlp[2*b+1] : $urandom;
            @(posedge clock); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic run(input int nb);
        model_tlp(nb);
        send(nb);
    endtask

    initial begin
        logic [63:0] addr;
        int sel, len, nb;
        bit ep;
        wr_t w; rd_t r;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_write_valid", write_valid, 0);
        check("rst_read_valid", read_valid, 0);
        check("rst_cpl_valid", completion_valid, 0);
        check("rst_write_address", write_address, 0);
        check("rst_completion_index", completion_index, 0);
        check("rst_rid_tag", rid_tag, 0);
        check("rst_stats", {stat_writes, stat_reads, stat_cpls, stat_drops}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // MWr3DW anchored on fixed expected words
        mk_mwr(1'b0, 64'h100, 4, 1'b0);
        tlp[3] = 32'h11223344; tlp[4] = 32'h55667788;
        tlp[5] = 32'h99AABBCC; tlp[6] = 32'hDDEEFF00;
        w.a = 13'h20; w.d = 64'h8877665544332211; wq.push_back(w);
        w.a = 13'h21; w.d = 64'h00FFEEDDCCBBAA99; wq.push_back(w);
        exp_wr++;
        send(full_beats());

        mk_mrd(1'b0, 64'h40, 2, 1'b0, 24'hABCD5E);
        r.a = 13'h8; r.n = 2'd2; r.rt = 24'hABCD5E; rq.push_back(r);
        exp_rd++;
        send(full_beats());

        mk_mrd(1'b0, 64'h80, 3, 1'b0, 24'h123456);
        run(full_beats());
        mk_mwr(1'b1, 64'h0000_0001_0000_0008, 2, 1'b0);
        run(full_beats());
        mk_cpl(12'd64, 8'h12, 16, 3'd0, 1'b0);
        run(full_beats());
        mk_cpl(12'd64, 8'h12, 16, 3'd1, 1'b0);
        run(full_beats());

        // Truncated MWr followed back-to-back by a complete one
        mk_mwr(1'b0, 64'h200, 4, 1'b0);
        run(3);
        mk_mwr(1'b0, 64'h300, 6, 1'b0);
        run(full_beats());

        // Reset while CplD data is streaming: only the word from beat 2 survives
        repeat (4) @(posedge clock); #1;
        mk_cpl(12'd128, 8'h77, 16, 3'd0, 1'b0);
        model_tlp(3);
        send(4);
        reset = 1'b1;
        exp_wr = 0; exp_rd = 0; exp_cpl = 0; exp_drop = 0;
        @(posedge clock);
        @(negedge clock);
        check("reset_cpl_valid", completion_valid, 0);
        check("reset_stats", {stat_writes, stat_reads, stat_cpls, stat_drops}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        mk_mwr(1'b0, 64'h408, 2, 1'b0);
        run(full_beats());

        for (int i = 0; i < 200; i++) begin
            gap_en = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 7);
            ep  = ($urandom_range(0, 11) == 0);
            addr = {$urandom, $urandom};
            addr[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) addr[2] = 1'b0;
            case (sel)
                0, 1, 2: begin
                    len = 2 * $urandom_range(1, 4);
                    if ($urandom_range(0, 7) == 0) len++;
                    mk_mwr($urandom_range(0, 1) == 1, addr, len, ep);
                end
                3, 4: mk_mrd($urandom_range(0, 1) == 1, addr, $urandom_range(1, 3), ep,
                             24'($urandom));
                5, 6: mk_cpl(12'($urandom), 8'($urandom), 2 * $urandom_range(1, 4),
                             ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0, ep);
                default: begin
                    mk_hdr0(7'h44, 2, 1'b0);
                    repeat (4) tlp.push_back($urandom);
                end
            endcase
            nb = full_beats();
            if ($urandom_range(0, 7) == 0) nb = $urandom_range(1, nb);
            run(nb);
        end

        for (int t = 0; t < 50 && (wq.size() + rq.size() + cq.size()) != 0; t++)
            @(posedge clock);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("pending_writes", wq.size(), 0);
        check("pending_reads", rq.size(), 0);
        check("pending_cpls", cq.size(), 0);
`ifdef PCIE_RX_STATS_EN
        check("stat_writes", stat_writes, 16'(exp_wr));
        check("stat_reads", stat_reads, 16'(exp_rd));
        check("stat_cpls", stat_cpls, 16'(exp_cpl));
        check("stat_drops", stat_drops, 16'(exp_drop));
`else
        check("stats_tied", {stat_writes, stat_reads, stat_cpls, stat_drops}, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pcie_rx_tlp_decoder.md
Name: pcie_rx_tlp_decoder

Overview:
Parametrised next-generation PCIe receive TLP decoder on the 64-bit AXI-stream from the PCIe hard core. Decodes memory writes and memory reads with 3DW (32-bit) or 4DW (64-bit) headers, plus successful CplD.
- Writes and CplD: emits one realigned, per-DW byte-reversed 64-bit data word per cycle, with incrementing word address or completion index.
- Reads and CplD: passes requester ID, tag and completion metadata downstream.
- Unsupported, poisoned or malformed TLPs are dropped whole.

Parameters:
ADDR_WIDTH, 13, width of 8-byte word address (byte address bits [ADDR_WIDTH+2:3]).
CPL_INDEX_WIDTH, 6, width of completion word index within a tag's buffer.

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-high
tvalid  input  1  stream beat valid; block always accepts (no tready)
tlast  input  1  last beat of TLP
tdata  input  64  DW0 in [31:0], DW1 in [63:32]
write_valid  output  1  one 64-bit write word valid
write_address  output  ADDR_WIDTH  word address of write_data
write_data  output  64  write data word
read_valid  output  1  single-cycle read request strobe
read_address  output  ADDR_WIDTH  word address of read
read_dw_count  output  2  1 or 2 DWs requested
rid_tag  output  24  {requester ID, tag} from DW1[31:8] of request
completion_valid  output  1  one 64-bit completion word valid
completion_tag  output  8  tag from CplD DW2[15:8]
completion_index  output  CPL_INDEX_WIDTH  word index of completion_data
completion_data  output  64  completion data word
stat_writes, stat_reads, stat_cpls, stat_drops  output  16 each  TLP counters (see Optional Feature)

Behaviour:
- Reset values:
  - All valids and counters 0.
  - Data, address, index and tag registers 0.
  - FSM in HDR01.
- Input registered one cycle. Outputs registered. Latency from input beat to valid pulse is 2 clocks.
- Byte order: each output DW is byte-reversed versus the wire (out[7:0]=dw[31:24] ... out[31:24]=dw[7:0]). The lower-address DW goes in out[31:0].
- Decode from beat 0, DW0[30:24]:
  - 0x40 = MWr3DW
  - 0x60 = MWr4DW
  - 0x00 = MRd3DW
  - 0x20 = MRd4DW
  - 0x4A = CplD
  - anything else is DROP.
- Also DROP when any of the following holds:
  - EP bit DW0[14] is set.
  - MWr with odd length or address bit 2 set.
  - MRd with length not 1 or 2.
  - CplD with status DW1[15:13] != 0.
- FSM states: HDR01 -> HDR23 -> DATA | DROP.
  - HDR01: latch type, length, rid_tag. For CplD, completion_index <= 0 - byte_count[CPL_INDEX_WIDTH+2:3].
  - HDR23: latch address from DW2 (3DW) or DW3 (4DW); upper address DW of 4DW is ignored. Latch tag from DW2[15:8] (CplD).
  - HDR23, MRd: read_valid pulses once; then wait in DROP for tlast.
- DATA, 3DW header (MWr3DW, CplD): word = {current low DW, previous high DW}. Beat 2 pairs DW3 and DW4.
- DATA, 4DW header: word = current beat.
- DATA, per emitted word: write_address or completion_index increments by 1, wrapping modulo 2^width. The first word uses the latched address or index.
- tvalid low stalls the FSM; no outputs are produced.
- tvalid&&tlast on any beat returns to HDR01 next cycle.
  - A truncated TLP emits only the words already complete; no partial word.
  - tlast on beat 0 drops the TLP.
- A beat carrying both tlast and the final data word emits that word, then returns to HDR01. Back-to-back TLPs need no idle cycle.
- Reset at any time: state HDR01, valids low on the next cycle; in-flight TLP is abandoned.

Optional Feature:
- Macro PCIE_RX_STATS_EN.
- Defined: stat_* are 16-bit saturating counters. Each increments once per TLP in the HDR23 decision cycle (writes, reads, CplD accepted, drops). Cleared by reset.
- Undefined: stat_* tied to 0, no counter logic.

Test Plan:
- MWr3DW, addr 0x100, length 4, data DWs 0x11223344,0x55667788,0x99AABBCC,0xDDEEFF00 -> two write_valid cycles:
  - write_address 0x20, write_data 0x8877665544332211.
  - write_address 0x21, write_data 0x00FFEEDDCCBBAA99.
- MWr4DW, addr 0x0000_0001_0000_0008, length 2 -> one write_valid, write_address 0x1, data unshifted from beat 2.
- MRd3DW, length 2, RID 0xABCD, tag 0x5E, addr 0x40 -> single read_valid: rid_tag 0xABCD5E, read_address 0x8, read_dw_count 2. MRd length 3 -> no strobe, stat_drops+1.
- CplD, byte count 64, tag 0x12, 16 DW -> 8 completion_valid, completion_tag 0x12, index 56..63. Same with status 1 -> no valid.
- MWr length 4 with tlast on beat 2, then back-to-back MWr -> one word from first TLP, second TLP fully decoded.
- Reset asserted mid-CplD data -> completion_valid low next cycle; following clean MWr decoded correctly. With PCIE_RX_STATS_EN, counters read 0 after reset.
